ras_guard: RTL and testbench

//  Hardware return-address stack beside Fetch/Decode. Consumes the decode-stage control-transfer info from

---
 rtl/ras_guard_pkg.sv | 23 ++
 rtl/ras_guard_if.sv | 34 +++
 rtl/ras_guard_lifo.sv | 67 ++++++
 rtl/ras_guard.sv | 116 +++++++++++
 tb/tb_ras_guard.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/ras_guard_pkg.sv
// Shared types and decode helpers for the return-address-stack guard.
// Build option RAS_CIRCULAR_EN (see ras_lifo) changes full-stack push behaviour.
package ras_pkg;

    typedef enum logic [1:0] {
        RAS_IDLE,
        RAS_CHECK,
        RAS_FAULT
    } ras_state_t;

    localparam logic [4:0] RA_REG   = 5'd1;
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Link-register write marks a call, whether it came from JAL or JALR.
    function automatic logic is_call(input logic jal, input logic jalr, input logic [4:0] rd);
        return (jal | jalr) && (rd == RA_REG);
    endfunction

    function automatic logic is_ret(input logic jalr, input logic [4:0] rd, input logic [4:0] rs1);
        return jalr && (rd == ZERO_REG) && (rs1 == RA_REG);
    endfunction

endpackage

// File: rtl/ras_guard_if.sv
// Decode-side control-transfer bus into the RAS guard plus its status outputs.
interface ras_guard_if #(
    parameter int DEPTH = 16,
    parameter int AW    = 32
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic          mem_hold;
    logic          IF_ID_jal;
    logic          IF_ID_jalr;
    logic [4:0]    IF_ID_rd;
    logic [4:0]    IF_ID_rs1;
    logic [AW-1:0] IF_ID_pres_addr;
    logic [AW-1:0] branoff;
    logic          fault_clr;
    logic          RAS_rdy;
    logic          ras_mismatch;
    logic          ras_overflow;
    logic          ras_underflow;
    logic [DW-1:0] ras_depth;

    modport master (
        output mem_hold, IF_ID_jal, IF_ID_jalr, IF_ID_rd, IF_ID_rs1,
               IF_ID_pres_addr, branoff, fault_clr,
        input  RAS_rdy, ras_mismatch, ras_overflow, ras_underflow, ras_depth
    );

    modport slave (
        input  mem_hold, IF_ID_jal, IF_ID_jalr, IF_ID_rd, IF_ID_rs1,
               IF_ID_pres_addr, branoff, fault_clr,
        output RAS_rdy, ras_mismatch, ras_overflow, ras_underflow, ras_depth
    );

endinterface

// File: rtl/ras_guard_lifo.sv
// Return-address storage: DEPTH x AW register stack with live depth count.
// RAS_CIRCULAR_EN: a push at full overwrites the oldest entry instead of being dropped.
module ras_lifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int DW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_data,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] depth
);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] top_idx;

    assign full     = (cnt_q == DW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign depth    = cnt_q;
    assign top_idx  = ptr_q - PW'(1);
    assign top_data = mem_q[top_idx];

    // ptr_q is the next free slot; it wraps naturally since DEPTH is a power of two.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - DW'(1);
        end else if (push && !pop) begin
`ifdef RAS_CIRCULAR_EN
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (!full) cnt_d = cnt_q + DW'(1);
`else
            if (!full) begin
                mem_d[ptr_q] = push_data;
                ptr_d        = ptr_q + PW'(1);
                cnt_d        = cnt_q + DW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ras_guard.sv
// Return-address stack guard: checks each function return against its call site and stalls fetch.
// Build option RAS_CIRCULAR_EN selects overwrite-oldest on a full-stack push.
module ras_guard
    import ras_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 32,
    localparam int DW   = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        Rst_n,
    ras_guard_if.slave  bus
);

    ras_state_t    state_q, state_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic [AW-1:0] ra_q, ra_d;
    logic          mismatch_q, mismatch_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          call, ret;
    logic          push, pop;
    logic [AW-1:0] top_data;
    logic          full, empty;
    logic [DW-1:0] depth;

    assign call = is_call(bus.IF_ID_jal, bus.IF_ID_jalr, bus.IF_ID_rd);
    assign ret  = is_ret(bus.IF_ID_jalr, bus.IF_ID_rd, bus.IF_ID_rs1);

    ras_lifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (Rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (bus.IF_ID_pres_addr + AW'(4)),
        .top_data  (top_data),
        .full      (full),
        .empty     (empty),
        .depth     (depth)
    );

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= RAS_IDLE;
            tgt_q       <= '0;
            ra_q        <= '0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            ra_q        <= ra_d;
            mismatch_q  <= mismatch_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack traffic only happens from IDLE; the decode slot is frozen while we stall,
    // so anything seen in CHECK/FAULT is the same instruction again.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        ra_d        = ra_q;
        mismatch_d  = mismatch_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;
        pop         = 1'b0;
        if (!bus.mem_hold) begin
            unique case (state_q)
                RAS_IDLE: begin
                    if (ret) begin
                        if (empty) begin
                            underflow_d = 1'b1;
                        end else begin
                            pop     = 1'b1;
                            tgt_d   = bus.branoff;
                            ra_d    = top_data;
                            state_d = RAS_CHECK;
                        end
                    end else if (call) begin
                        push = 1'b1;
                        if (full) overflow_d = 1'b1;
                    end
                end
                RAS_CHECK: begin
                    if (tgt_q == ra_q) begin
                        state_d = RAS_IDLE;
                    end else begin
                        state_d    = RAS_FAULT;
                        mismatch_d = 1'b1;
                    end
                end
                RAS_FAULT: begin
                    if (bus.fault_clr) state_d = RAS_IDLE;
                end
                default: state_d = RAS_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.RAS_rdy       = (state_q == RAS_IDLE);
        bus.ras_mismatch  = mismatch_q;
        bus.ras_overflow  = overflow_q;
        bus.ras_underflow = underflow_q;
        bus.ras_depth     = depth;
    end

endmodule

// File: tb/tb_ras_guard.sv
// Directed vector bench for ras_guard: table of per-cycle stimulus/expectations plus corner sequences.
module tb_ras_guard;

    localparam int DEPTH = 16;
    localparam int AW    = 32;

    typedef struct {
        logic        hold, jal, jalr;
        logic [4:0]  rd, rs1;
        logic [31:0] pc, br;
        logic        clr;
        logic        rdy, mis, ovf, unf;
        logic [4:0]  dep;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    vec_t tv[$];

    ras_guard_if #(.DEPTH(DEPTH), .AW(AW)) bus();

    ras_guard #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic hold, input logic jal, input logic jalr,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [31:0] pc, input logic [31:0] br, input logic clr,
                                input logic rdy, input logic mis, input logic ovf,
                                input logic unf, input logic [4:0] dep);
        vec_t v;
        v.hold = hold; v.jal = jal; v.jalr = jalr; v.rd = rd; v.rs1 = rs1;
        v.pc = pc; v.br = br; v.clr = clr;
        v.rdy = rdy; v.mis = mis; v.ovf = ovf; v.unf = unf; v.dep = dep;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic drive(input logic hold, input logic jal, input logic jalr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [31:0] pc, input logic [31:0] br,
                         input logic clr);
        bus.mem_hold        = hold;
        bus.IF_ID_jal       = jal;
        bus.IF_ID_jalr      = jalr;
        bus.IF_ID_rd        = rd;
        bus.IF_ID_rs1       = rs1;
        bus.IF_ID_pres_addr = pc;
        bus.branoff         = br;
        bus.fault_clr       = clr;
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic cyc(input logic hold, input logic jal, input logic jalr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [31:0] pc, input logic [31:0] br,
                       input logic clr);
        @(negedge clk);
        drive(hold, jal, jalr, rd, rs1, pc, br, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic rdy, input logic mis,
                           input logic ovf, input logic unf, input logic [4:0] dep);
        chk({tag, ".rdy"}, idx, 32'(bus.RAS_rdy), 32'(rdy));
        chk({tag, ".mismatch"}, idx, 32'(bus.ras_mismatch), 32'(mis));
        chk({tag, ".overflow"}, idx, 32'(bus.ras_overflow), 32'(ovf));
        chk({tag, ".underflow"}, idx, 32'(bus.ras_underflow), 32'(unf));
        chk({tag, ".depth"}, idx, 32'(bus.ras_depth), 32'(dep));
    endtask

    initial begin
        logic [31:0] base;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        //            hold jal jalr rd  rs1 pc            br            clr  rdy mis ovf unf dep
        // simple matched call/return
        tv.push_back(mk(0, 1, 0, 1, 0, 32'h100,      32'h0,        0,   1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 1, 0, 1, 32'h0,        32'h104,      0,   0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 0, 0, 0, 0));
        // return address wraps modulo 2^AW
        tv.push_back(mk(0, 1, 0, 1, 0, 32'hFFFFFFFC, 32'h0,        0,   1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 1, 0, 1, 32'h0,        32'h0,        0,   0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 0, 0, 0, 0));
        // call held under mem_hold for 3 cycles, then exactly one push
        tv.push_back(mk(1, 1, 0, 1, 0, 32'h300,      32'h0,        0,   1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 0, 32'h300,      32'h0,        0,   1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 0, 32'h300,      32'h0,        0,   1, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 1, 0, 32'h300,      32'h0,        0,   1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 1, 0, 1, 32'h0,        32'h304,      0,   0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 0, 0, 0, 0));
        // JALR rd=ra is a call; other JALR/JAL forms are neither push nor pop
        tv.push_back(mk(0, 0, 1, 1, 5, 32'h600,      32'h0,        0,   1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 1, 0, 2, 32'h0,        32'h999,      0,   1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 1, 5, 1, 32'h0,        32'h999,      0,   1, 0, 0, 0, 1));
        tv.push_back(mk(0, 1, 0, 0, 0, 32'h0,        32'h0,        0,   1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 1, 0, 1, 32'h0,        32'h604,      0,   0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 1, 0, 32'h700,      32'h0,        0,   1, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 0, 0, 0, 0));
        // mismatching return -> FAULT until fault_clr
        tv.push_back(mk(0, 1, 0, 1, 0, 32'h100,      32'h0,        0,   1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 1, 0, 1, 32'h0,        32'h200,      0,   0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 1, 0, 32'h500,      32'h0,        0,   0, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   0, 1, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        1,   0, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 1, 32'h0,        32'h0,        0,   0, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        1,   1, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 1, 0, 0, 0));
        // return on empty stack: unchecked, underflow flagged
        tv.push_back(mk(0, 0, 1, 0, 1, 32'h0,        32'h0,        0,   1, 1, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 1, 0, 1, 0));

        #12;
        chk_all("reset", 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].hold, tv[i].jal, tv[i].jalr, tv[i].rd, tv[i].rs1, tv[i].pc, tv[i].br, tv[i].clr);
            chk_all("vec", i, tv[i].rdy, tv[i].mis, tv[i].ovf, tv[i].unf, tv[i].dep);
        end

        // asynchronous reset while in CHECK
        cyc(0, 1, 0, 1, 0, 32'h800, 32'h0, 0);
        cyc(0, 0, 1, 0, 1, 32'h0, 32'h804, 0);
        chk("arst.pre_rdy", 0, 32'(bus.RAS_rdy), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("arst", 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // DEPTH+1 nested calls, then unwind
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(0, 1, 0, 1, 0, 32'(4 * i), 32'h0, 0);
            chk("nest.depth", i, 32'(bus.ras_depth), (i < DEPTH) ? 32'(i + 1) : 32'(DEPTH));
            chk("nest.ovf", i, 32'(bus.ras_overflow), (i < DEPTH) ? 32'd0 : 32'd1);
        end
`ifdef RAS_CIRCULAR_EN
        base = 32'h8;
`else
        base = 32'h4;
`endif
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cyc(0, 0, 1, 0, 1, 32'h0, base + 32'(4 * i), 0);
            chk("unwind.rdy_chk", i, 32'(bus.RAS_rdy), 32'd0);
            chk("unwind.depth", i, 32'(bus.ras_depth), 32'(i));
            cyc(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
            chk("unwind.rdy", i, 32'(bus.RAS_rdy), 32'd1);
            chk("unwind.mis", i, 32'(bus.ras_mismatch), 32'd0);
        end
        cyc(0, 0, 1, 0, 1, 32'h0, base - 32'h4, 0);
        chk_all("deep_ret", 0, 1, 0, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
